// File: rtl/layer3_idb_weight_router_pkg.sv
// Shared layer3 identity-block constants: channel/kernel products, segment lengths,
// the derived segment counter width and the weight router FSM encoding.
package layer3_idb_weight_router_pkg;

    localparam int L3_IDB_C1_IN  = 1024;
    localparam int L3_IDB_C1_OUT = 256;
    localparam int L3_IDB_C1_K   = 1;
    localparam int L3_IDB_C2_IN  = 256;
    localparam int L3_IDB_C2_OUT = 256;
    localparam int L3_IDB_C2_K   = 3;
    localparam int L3_IDB_C3_IN  = 256;
    localparam int L3_IDB_C3_OUT = 1024;
    localparam int L3_IDB_C3_K   = 1;

    localparam int L3_IDB_W1_COUNT = L3_IDB_C1_IN * L3_IDB_C1_OUT * L3_IDB_C1_K * L3_IDB_C1_K;
    localparam int L3_IDB_W2_COUNT = L3_IDB_C2_IN * L3_IDB_C2_OUT * L3_IDB_C2_K * L3_IDB_C2_K;
    localparam int L3_IDB_W3_COUNT = L3_IDB_C3_IN * L3_IDB_C3_OUT * L3_IDB_C3_K * L3_IDB_C3_K;

    localparam int L3_IDB_W_MAX =
        (L3_IDB_W1_COUNT > L3_IDB_W2_COUNT)
            ? ((L3_IDB_W1_COUNT > L3_IDB_W3_COUNT) ? L3_IDB_W1_COUNT : L3_IDB_W3_COUNT)
            : ((L3_IDB_W2_COUNT > L3_IDB_W3_COUNT) ? L3_IDB_W2_COUNT : L3_IDB_W3_COUNT);
    localparam int L3_IDB_CNT_WIDTH = $clog2(L3_IDB_W_MAX);

    typedef enum logic [1:0] {
        ST_LOAD1 = 2'd0,
        ST_LOAD2 = 2'd1,
        ST_LOAD3 = 2'd2,
        ST_DONE  = 2'd3
    } router_state_t;

endpackage

// File: rtl/layer3_idb_weight_router.sv
// Steers one serial weight stream into the conv1/conv2/conv3 ports by counted segments.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; words arriving after the last segment are dropped and flag overflow.
module layer3_idb_weight_router
    import layer3_idb_weight_router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int W1_COUNT   = L3_IDB_W1_COUNT,
    parameter int W2_COUNT   = L3_IDB_W2_COUNT,
    parameter int W3_COUNT   = L3_IDB_W3_COUNT,
    parameter int CNT_WIDTH  = L3_IDB_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  reload,
    output logic                  valid_weight_out1,
    output logic [DATA_WIDTH-1:0] weight_out1,
    output logic                  valid_weight_out2,
    output logic [DATA_WIDTH-1:0] weight_out2,
    output logic                  valid_weight_out3,
    output logic [DATA_WIDTH-1:0] weight_out3,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [CNT_WIDTH-1:0] W1_LAST = CNT_WIDTH'(W1_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] W2_LAST = CNT_WIDTH'(W2_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] W3_LAST = CNT_WIDTH'(W3_COUNT - 1);

    router_state_t        state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [2:0]           route;
    logic                 ovf_set;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        route     = 3'b000;
        ovf_set   = 1'b0;
        // reload wins over a same-cycle word, which is simply not routed
        if (reload) begin
            state_nxt = ST_LOAD1;
            cnt_nxt   = '0;
        end else if (valid_in) begin
            case (state)
                ST_LOAD1: begin
                    route = 3'b001;
                    if (cnt == W1_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_LOAD2;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_LOAD2: begin
                    route = 3'b010;
                    if (cnt == W2_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_LOAD3;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_LOAD3: begin
                    route = 3'b100;
                    if (cnt == W3_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: ovf_set = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_LOAD1;
            cnt               <= '0;
            valid_weight_out1 <= 1'b0;
            valid_weight_out2 <= 1'b0;
            valid_weight_out3 <= 1'b0;
            weight_out1       <= '0;
            weight_out2       <= '0;
            weight_out3       <= '0;
            done              <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            valid_weight_out1 <= route[0];
            valid_weight_out2 <= route[1];
            valid_weight_out3 <= route[2];
            if (route[0]) weight_out1 <= weight_in;
            if (route[1]) weight_out2 <= weight_in;
            if (route[2]) weight_out3 <= weight_in;
            // done tracks the registered state so it lines up with the last conv3 pulse
            done <= (state_nxt == ST_DONE);
            if (reload) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer3_idb_weight_router.sv
// Directed bench for layer3_idb_weight_router with short segments (4/9/4).
module tb_layer3_idb_weight_router;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] weight_in;
    logic          reload;
    logic          valid_weight_out1, valid_weight_out2, valid_weight_out3;
    logic [DW-1:0] weight_out1, weight_out2, weight_out3;
    logic          done;
    logic          overflow;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_w [1:3];
    int            gaps  [17] = '{1, 0, 3, 2, 0, 1, 3, 0, 2, 1, 0, 3, 0, 2, 1, 0, 3};

    always #5 clk = ~clk;

    layer3_idb_weight_router #(
        .DATA_WIDTH(DW),
        .W1_COUNT  (4),
        .W2_COUNT  (9),
        .W3_COUNT  (4),
        .CNT_WIDTH (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .weight_in        (weight_in),
        .reload           (reload),
        .valid_weight_out1(valid_weight_out1),
        .weight_out1      (weight_out1),
        .valid_weight_out2(valid_weight_out2),
        .weight_out2      (weight_out2),
        .valid_weight_out3(valid_weight_out3),
        .weight_out3      (weight_out3),
        .done             (done),
        .overflow         (overflow)
    );

    function automatic logic [DW-1:0] word(input int i);
        return 32'h4000_0000 | DW'(i);
    endfunction

    // Expected port of the i-th word (1-based) in a fresh 4/9/4 image
    function automatic int port_of(input int i);
        if (i <= 4)  return 1;
        if (i <= 13) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int port, input logic exp_done,
                              input logic exp_ovf);
        chk({tag, ".v1"}, DW'(valid_weight_out1), DW'(port == 1));
        chk({tag, ".v2"}, DW'(valid_weight_out2), DW'(port == 2));
        chk({tag, ".v3"}, DW'(valid_weight_out3), DW'(port == 3));
        chk({tag, ".w1"}, weight_out1, exp_w[1]);
        chk({tag, ".w2"}, weight_out2, exp_w[2]);
        chk({tag, ".w3"}, weight_out3, exp_w[3]);
        chk({tag, ".done"}, DW'(done), DW'(exp_done));
        chk({tag, ".ovf"}, DW'(overflow), DW'(exp_ovf));
    endtask

    task automatic send_word(input string tag, input logic [DW-1:0] w, input int port,
                             input logic exp_done, input logic exp_ovf);
        valid_in  = 1'b1;
        weight_in = w;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (port != 0) exp_w[port] = w;
        check_outs(tag, port, exp_done, exp_ovf);
    endtask

    task automatic idle(input string tag, input logic exp_done, input logic exp_ovf);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_outs(tag, 0, exp_done, exp_ovf);
    endtask

    task automatic do_reload(input string tag, input logic v, input logic [DW-1:0] w);
        reload    = 1'b1;
        valid_in  = v;
        weight_in = w;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        valid_in = 1'b0;
        check_outs(tag, 0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_w[1] = '0;
        exp_w[2] = '0;
        exp_w[3] = '0;

        // Reset held with a live word on the input: nothing may leak out
        reset     = 1'b1;
        reload    = 1'b0;
        valid_in  = 1'b1;
        weight_in = 32'h3F80_0000;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outs("reset", 0, 1'b0, 1'b0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        exp_w[1] = 32'h3F80_0000;
        check_outs("first_word", 1, 1'b0, 1'b0);

        // Reset after one accepted word clears progress and outputs
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_w[1] = '0;
        check_outs("reset_again", 0, 1'b0, 1'b0);

        for (int i = 1; i <= 17; i++)
            send_word($sformatf("b2b[%0d]", i), word(i), port_of(i), i == 17, 1'b0);
        idle("b2b_hold", 1'b1, 1'b0);

        // Words after DONE are dropped and set a sticky overflow
        send_word("extra1", 32'hDEAD_0001, 0, 1'b1, 1'b1);
        send_word("extra2", 32'hDEAD_0002, 0, 1'b1, 1'b1);
        idle("ovf_sticky", 1'b1, 1'b1);
        do_reload("reload_clr", 1'b0, 32'h0);

        for (int i = 1; i <= 17; i++) begin
            send_word($sformatf("gap[%0d]", i), word(100 + i), port_of(i), i == 17, 1'b0);
            for (int g = 0; g < gaps[i-1]; g++)
                idle($sformatf("gap_idle[%0d]", i), i == 17, 1'b0);
        end

        // Reload mid-conv2 with a same-cycle word: that word vanishes, count restarts
        do_reload("reload_pre", 1'b0, 32'h0);
        for (int i = 1; i <= 6; i++)
            send_word($sformatf("mid[%0d]", i), word(200 + i), port_of(i), 1'b0, 1'b0);
        do_reload("reload_w7", 1'b1, word(207));
        for (int i = 1; i <= 4; i++)
            send_word($sformatf("after_rl[%0d]", i), word(300 + i), 1, 1'b0, 1'b0);
        send_word("after_rl[5]", word(305), 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
